// File: rtl/multi_fifo_drain_arb_pkg.sv
// Shared types and helpers for the multi-FIFO drain arbiter: FSM states,
// OUT_SRC width derivation and the rotate-and-find-first search.
package multi_fifo_drain_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2
    } state_t;

    localparam int MAX_FIFOS = 64;
    localparam int MAX_IDX_W = 6;

    function automatic int src_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    // First set bit of req[n-1:0] searching upward from start and wrapping; -1 if none.
    function automatic int find_first_from(input logic [MAX_FIFOS-1:0] req,
                                           input int n, input int start);
        int idx;
        int found;
        found = -1;
        for (int k = MAX_FIFOS - 1; k >= 0; k--) begin
            if (k < n) begin
                idx = start + k;
                if (idx >= n) idx = idx - n;
                if (req[idx[MAX_IDX_W-1:0]]) found = idx;
            end
        end
        return found;
    endfunction

endpackage

// File: rtl/multi_fifo_drain_arb_rr_grant.sv
// Grant selector for the drain arbiter. Round-robin by default; defining
// MFD_STRICT_PRIO_EN switches to fixed lowest-index-first priority.
module rr_grant
    import multi_fifo_drain_pkg::*;
#(
    parameter int NUM_FIFOS = 4,
    parameter int SRC_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_FIFOS-1:0] req,
    input  logic                 advance,
    output logic [SRC_WIDTH-1:0] grant,
    output logic                 any_req
);

    logic [MAX_FIFOS-1:0] req_ext;
    int                   start;
    int                   sel;

`ifdef MFD_STRICT_PRIO_EN
    logic strict_unused;
    assign strict_unused = ^{clk, rst, advance};
    assign start = 0;
`else
    logic [SRC_WIDTH-1:0] last_grant;

    // Reset to the top index so FIFO 0 is the first one searched.
    always_ff @(posedge clk) begin
        if (rst)
            last_grant <= SRC_WIDTH'(NUM_FIFOS - 1);
        else if (advance)
            last_grant <= grant;
    end

    assign start = (int'(last_grant) >= NUM_FIFOS - 1) ? 0 : int'(last_grant) + 1;
`endif

    always_comb begin
        req_ext = '0;
        req_ext[NUM_FIFOS-1:0] = req;
        sel = find_first_from(req_ext, NUM_FIFOS, start);
    end

    assign any_req = |req;
    assign grant   = (sel < 0) ? '0 : SRC_WIDTH'(sel);

endmodule

// File: rtl/multi_fifo_drain_arb.sv
// Pops NUM_FIFOS FIFOs one word at a time and merges them into a single
// valid/ready stream tagged with the source index. Macro: MFD_STRICT_PRIO_EN.
module multi_fifo_drain_arb
    import multi_fifo_drain_pkg::*;
#(
    parameter  int DATA_WIDTH = 8,
    parameter  int NUM_FIFOS  = 4,
    localparam int SRC_WIDTH  = src_width(NUM_FIFOS)
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic [NUM_FIFOS-1:0]           FIFO_EMPTY,
    input  logic [NUM_FIFOS*DATA_WIDTH-1:0] FIFO_DOUT,
    output logic [NUM_FIFOS-1:0]           FIFO_RD_EN,
    output logic                           OUT_VALID,
    input  logic                           OUT_READY,
    output logic [DATA_WIDTH-1:0]          OUT_DATA,
    output logic [SRC_WIDTH-1:0]           OUT_SRC
);

    state_t                 state;
    state_t                 next_state;
    logic [NUM_FIFOS-1:0]   req;
    logic [NUM_FIFOS-1:0]   rd_en;
    logic [SRC_WIDTH-1:0]   grant;
    logic [SRC_WIDTH-1:0]   pending;
    logic                   any_req;
    logic                   advance;
    logic [DATA_WIDTH-1:0]  dout_sel;

    assign req        = ~FIFO_EMPTY;
    assign advance    = |rd_en;
    assign FIFO_RD_EN = rd_en;

    rr_grant #(
        .NUM_FIFOS (NUM_FIFOS),
        .SRC_WIDTH (SRC_WIDTH)
    ) u_grant (
        .clk     (CLK),
        .rst     (RST),
        .req     (req),
        .advance (advance),
        .grant   (grant),
        .any_req (any_req)
    );

    // A new pop is only issued when the output slot is free or being freed this cycle.
    always_comb begin
        next_state = state;
        rd_en      = '0;
        if (!RST) begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        rd_en[grant] = 1'b1;
                        next_state   = FETCH;
                    end
                end
                FETCH: next_state = SEND;
                SEND: begin
                    if (OUT_READY) begin
                        if (any_req) begin
                            rd_en[grant] = 1'b1;
                            next_state   = FETCH;
                        end else begin
                            next_state = IDLE;
                        end
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        dout_sel = '0;
        for (int i = 0; i < NUM_FIFOS; i++) begin
            if (pending == SRC_WIDTH'(i))
                dout_sel = FIFO_DOUT[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            pending   <= '0;
            OUT_VALID <= 1'b0;
            OUT_DATA  <= '0;
            OUT_SRC   <= '0;
        end else begin
            state <= next_state;
            if (advance)
                pending <= grant;
            case (state)
                FETCH: begin
                    OUT_DATA  <= dout_sel;
                    OUT_SRC   <= pending;
                    OUT_VALID <= 1'b1;
                end
                SEND: begin
                    if (OUT_READY)
                        OUT_VALID <= 1'b0;
                end
                default: OUT_VALID <= 1'b0;
            endcase
        end
    end

endmodule
